vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48: horizontal front porch, sync and back porch, in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33: vertical porches and sync, in lines.
REQ-005 SHALL have parameter CLK_DIV, default 4: clk_100 cycles per pixel; minimum 1.
REQ-006 SHALL have parameters HS_POL/VS_POL, default 0/0: active sync level (0 = active-low).
REQ-007 SHALL have parameter COLOR_W, default 4: bits per colour channel.
REQ-008 SHALL have port clk_100, input, 1 bit: the single clock; all logic on its rising edge.
REQ-009 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-010 SHALL have port en, input, 1 bit: timing advance enable.
REQ-011 SHALL have port mode, input, 2 bits: 00 black, 01 colour bars, 10 checkerboard, 11 solid pix_in.
REQ-012 SHALL have port pix_in, input, 3*COLOR_W bits: {r,g,b} solid colour.
REQ-013 SHALL have ports hsync and vsync, output, 1 bit each: sync outputs.
REQ-014 SHALL have port de, output, 1 bit: display enable.
REQ-015 SHALL have ports x and y, output, clog2(H_ACTIVE) and clog2(V_ACTIVE) bits: active pixel coordinates, 0 outside active.
REQ-016 SHALL have port frame_start, output, 1 bit: one-clock pulse at frame wrap.
REQ-017 SHALL have ports vga_r, vga_g and vga_b, output, COLOR_W bits each: colour outputs.

Function
REQ-018 SHALL generate a pixel tick every CLK_DIV clocks with divider counting 0..CLK_DIV-1; CLK_DIV=1 SHALL give a tick every cycle.
REQ-019 SHALL advance h on each tick in 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; on the tick at h=H_TOTAL-1 it SHALL set h=0 and advance v, wrapping v at V_TOTAL-1.
REQ-020 SHALL register all outputs so they reflect the counter state one clock after each counter update.
REQ-021 SHALL assert de iff h<H_ACTIVE and v<V_ACTIVE.
REQ-022 SHALL drive hsync to HS_POL iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else to ~HS_POL.
REQ-023 SHALL drive vsync to VS_POL iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else to ~VS_POL; vsync SHALL change only at h=0.
REQ-024 SHALL pulse frame_start for exactly one clock when (h,v) wraps to (0,0); leaving reset SHALL NOT produce a pulse.
REQ-025 SHALL latch mode and pix_in into shadow registers only on the wrap to (0,0) and on reset; changes mid-frame SHALL have no effect until the next frame.
REQ-026 SHALL, with en=0, freeze the divider, counters and all outputs (frame_start=0); on en=1 it SHALL resume without skipping or repeating a pixel.
REQ-027 SHALL, in colour-bars mode, produce 8 bars of width H_ACTIVE/8 in the order white, yellow, cyan, green, magenta, red, blue, black, with full-scale = all ones; any remainder pixels on the right SHALL be black.
REQ-028 SHALL, in checkerboard mode, output white when x[5]^y[5] is 1, else black.
REQ-029 SHALL force rgb=0 whenever de=0, regardless of mode.

Reset
REQ-030 SHALL, with rst high at a clock edge, clear the divider, h and v to 0, drive hsync=~HS_POL, vsync=~VS_POL, de=0, x=y=0, frame_start=0 and rgb=0, and latch mode and pix_in into the shadow registers.
REQ-031 SHALL give rst priority over en; rst asserted mid-frame SHALL take effect at the next edge.
REQ-032 SHALL, on the first clock after rst deasserts, show pixel (0,0): de=1, x=0, y=0.

Verification (H 8/2/3/3, V 4/1/2/1, CLK_DIV=2, POL=0, COLOR_W=4)
REQ-033 SHALL cover reset: rst high 5 clocks -> hsync=1, vsync=1, de=0, rgb=0, frame_start=0.
REQ-034 SHALL cover line timing: measured from line start -> de high 16 clocks, hsync low for 6 clocks starting at clock 20, line period 32 clocks.
REQ-035 SHALL cover frame timing: vsync low 64 clocks starting at line 5; frame_start single-cycle pulse every 256 clocks.
REQ-036 SHALL cover mode switching: mode=01 -> x=0..7 gives FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000; switching to mode=11 with pix_in=0x5A3 at y=2 -> unchanged until frame_start, then 5A3 during de only.
REQ-037 SHALL cover enable hold: en=0 for 10 clocks mid-line -> x, y, hsync and de frozen; after release, x increments by exactly 1 per 2 clocks.
REQ-038 SHALL cover reset mid-frame: rst at v=3, h=5 -> reset values next clock, then (0,0) on the first clock after release, with no frame_start pulse.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/blanking timing generator with per-frame test-pattern colour output
// Ports: clk_100/rst clock and synchronous reset; en advances the pixel timing;
// mode/pix_in pick the pattern (shadowed once per frame); hsync/vsync/de/x/y/frame_start
// are the registered timing outputs; vga_r/vga_g/vga_b the registered colour channels.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int COLOR_W  = 4
) (
    input  logic                        clk_100,
    input  logic                        rst,
    input  logic                        en,
    input  logic [1:0]                  mode,
    input  logic [3*COLOR_W-1:0]        pix_in,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        de,
    output logic [$clog2(H_ACTIVE)-1:0] x,
    output logic [$clog2(V_ACTIVE)-1:0] y,
    output logic                        frame_start,
    output logic [COLOR_W-1:0]          vga_r,
    output logic [COLOR_W-1:0]          vga_g,
    output logic [COLOR_W-1:0]          vga_b
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int XW      = $clog2(H_ACTIVE);
    localparam int YW      = $clog2(V_ACTIVE);
    localparam int BAR_W   = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [DW-1:0]          r_div;
    logic [HW-1:0]          r_h;
    logic [VW-1:0]          r_v;
    logic [1:0]             r_mode;
    logic [3*COLOR_W-1:0]   r_pix;
    logic                   r_wrap;

    int                     w_h;
    int                     w_v;
    logic                   w_tick;
    logic                   w_eol;
    logic                   w_eof;
    logic                   w_de;
    logic                   w_hs_act;
    logic                   w_vs_act;
    logic [2:0]             w_bar;
    logic [3*COLOR_W-1:0]   w_bars;
    logic [3*COLOR_W-1:0]   w_chk;
    logic [3*COLOR_W-1:0]   w_rgb;

    assign w_h      = int'(r_h);
    assign w_v      = int'(r_v);
    assign w_tick   = en && (r_div == DW'(CLK_DIV - 1));
    assign w_eol    = (w_h == H_TOTAL - 1);
    assign w_eof    = w_eol && (w_v == V_TOTAL - 1);
    assign w_de     = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
    assign w_hs_act = (w_h >= H_ACTIVE + H_FP) && (w_h < H_ACTIVE + H_FP + H_SYNC);
    assign w_vs_act = (w_v >= V_ACTIVE + V_FP) && (w_v < V_ACTIVE + V_FP + V_SYNC);
    assign w_bar    = 3'(w_h / BAR_W);
    // Bar index bits map directly to channels: r=~b1, g=~b2, b=~b0 gives W,Y,C,G,M,R,B,K
    assign w_bars   = (w_h < 8 * BAR_W) ?
                      {{COLOR_W{~w_bar[1]}}, {COLOR_W{~w_bar[2]}}, {COLOR_W{~w_bar[0]}}} : '0;
    assign w_chk    = {3*COLOR_W{w_h[5] ^ w_v[5]}};
    assign w_rgb    = !w_de ? '0 :
                      (r_mode == 2'b01) ? w_bars :
                      (r_mode == 2'b10) ? w_chk :
                      (r_mode == 2'b11) ? r_pix : '0;

    // Outputs decode the counter state present before each edge, so they trail the
    // counters by one clock; r_wrap delays the wrap event to line up frame_start with (0,0).
    always_ff @(posedge clk_100) begin
        if (rst) begin
            r_div       <= '0;
            r_h         <= '0;
            r_v         <= '0;
            r_wrap      <= 1'b0;
            r_mode      <= mode;
            r_pix       <= pix_in;
            hsync       <= (HS_POL == 0);
            vsync       <= (VS_POL == 0);
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else if (en) begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            if (w_tick) begin
                r_h <= w_eol ? '0 : r_h + 1'b1;
                if (w_eol)
                    r_v <= w_eof ? '0 : r_v + 1'b1;
                if (w_eof) begin
                    r_mode <= mode;
                    r_pix  <= pix_in;
                end
            end
            r_wrap                <= w_tick && w_eof;
            hsync                 <= (w_hs_act == (HS_POL != 0));
            vsync                 <= (w_vs_act == (VS_POL != 0));
            de                    <= w_de;
            x                     <= w_de ? r_h[XW-1:0] : '0;
            y                     <= w_de ? r_v[YW-1:0] : '0;
            frame_start           <= r_wrap;
            {vga_r, vga_g, vga_b} <= w_rgb;
        end else begin
            frame_start <= 1'b0;
        end
    end
endmodule
